// File: rtl/lpf_pkg.sv
// Shared types and helpers for the multi-channel IIR low-pass filter.
package lpf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } lpf_state_e;

    // Limit alpha to 2^frac, which represents a gain of exactly 1.0.
    function automatic logic [31:0] clamp_alpha(input logic [31:0] a, input int frac);
        logic [31:0] one;
        one = 32'd1 << frac;
        if (a > one) begin
            return one;
        end else begin
            return a;
        end
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/lpf_update_core.sv
// Combinational single-channel update: copy when unprimed, else rounded and
// saturated y + alpha*(x - y).
module lpf_update_core
    import lpf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 5
) (
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_y,
    input  logic        [FRAC:0]    i_alpha,
    input  logic                    i_primed,
    output logic signed [WIDTH-1:0] o_y_next
);

    localparam int PW = WIDTH + FRAC + 2;

    logic signed [WIDTH:0]  w_diff;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_round;
    logic signed [PW-1:0]   w_sum;
    logic signed [63:0]     w_sat;

    // Adding half an LSB before the arithmetic shift rounds halves toward +inf.
    always_comb begin
        w_diff  = {i_x[WIDTH-1], i_x} - {i_y[WIDTH-1], i_y};
        w_prod  = $signed({{(PW-FRAC-1){1'b0}}, i_alpha})
                * $signed({{(PW-WIDTH-1){w_diff[WIDTH]}}, w_diff});
        w_round = (w_prod + PW'(1 << (FRAC - 1))) >>> FRAC;
        w_sum   = {{(PW-WIDTH){i_y[WIDTH-1]}}, i_y} + w_round;
        w_sat   = sat_signed(64'(w_sum), WIDTH);
        if (i_primed) begin
            o_y_next = w_sat[WIDTH-1:0];
        end else begin
            o_y_next = i_x;
        end
    end

endmodule

// File: rtl/lpf_multi.sv
// Multi-channel first-order IIR low-pass filter sharing one update core,
// time-multiplexed over the channels of each accepted frame.
module lpf_multi
    import lpf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 3,
    parameter int FRAC     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [FRAC:0]               alpha,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [CHANNELS*WIDTH-1:0]   out_data
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    lpf_state_e                 r_state;
    logic [CW-1:0]              r_ch;
    logic signed [WIDTH-1:0]    r_x [CHANNELS];
    logic signed [WIDTH-1:0]    r_y [CHANNELS];
    logic [FRAC:0]              r_alpha;
    logic                       r_frame_primed;
    logic                       r_primed;
    logic                       r_flush_seen;
    logic                       r_out_valid;
    logic [CHANNELS*WIDTH-1:0]  r_out;

    logic                       w_accept;
    logic                       w_last;
    logic [31:0]                w_alpha_clamped;
    logic signed [WIDTH-1:0]    w_y_next;
    logic [CHANNELS*WIDTH-1:0]  w_frame;

    assign in_ready        = !rst && (r_state != ST_PROC);
    assign w_accept        = in_valid && in_ready;
    assign w_last          = (r_ch == CW'(CHANNELS - 1));
    assign w_alpha_clamped = clamp_alpha(32'(alpha), FRAC);
    assign out_valid       = r_out_valid;
    assign out_data        = r_out;

    lpf_update_core #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_core (
        .i_x      (r_x[r_ch]),
        .i_y      (r_y[r_ch]),
        .i_alpha  (r_alpha),
        .i_primed (r_frame_primed),
        .o_y_next (w_y_next)
    );

    // The last channel's fresh result bypasses the state array into the output frame.
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CW'(i) == r_ch) begin
                w_frame[i*WIDTH +: WIDTH] = w_y_next;
            end else begin
                w_frame[i*WIDTH +: WIDTH] = r_y[i];
            end
        end
    end

    // A flush seen anywhere during a frame keeps primed clear at that frame's DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ch           <= '0;
            r_alpha        <= '0;
            r_frame_primed <= 1'b0;
            r_primed       <= 1'b0;
            r_flush_seen   <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out          <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_primed     <= 1'b0;
                r_flush_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_x[i] <= in_data[i*WIDTH +: WIDTH];
                        end
                        r_alpha        <= w_alpha_clamped[FRAC:0];
                        r_frame_primed <= r_primed && !flush;
                        r_flush_seen   <= 1'b0;
                        r_ch           <= '0;
                        r_state        <= ST_PROC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PROC: begin
                    r_y[r_ch] <= w_y_next;
                    if (w_last) begin
                        r_out       <= w_frame;
                        r_out_valid <= 1'b1;
                        r_primed    <= !(flush || r_flush_seen);
                        r_ch        <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpf_multi.sv
// Directed self-checking bench for lpf_multi (WIDTH=16, CHANNELS=3, FRAC=5).
module tb_lpf_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_data = '0;
    logic [5:0]  alpha = 6'd14;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [47:0] out_data;

    int checks = 0;
    int errors = 0;

    lpf_multi #(.WIDTH(16), .CHANNELS(3), .FRAC(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .alpha     (alpha),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 do_flush;
        logic signed [15:0] x0, x1, x2;
        logic [5:0]         al;
        logic signed [15:0] e0, e1, e2;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Offer one frame, wait for its out_valid; lat counts edges from accept to out_valid.
    task automatic send(input logic signed [15:0] a0, a1, a2, input logic [5:0] al,
                        output logic [47:0] got, output int lat);
        int wd;
        in_data  = {a2, a1, a0};
        alpha    = al;
        in_valid = 1'b1;
        wd = 0;
        while (!in_ready && wd < 20) begin
            tick();
            wd++;
        end
        if (wd >= 20) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: in_ready stayed low for %0d cycles", wd);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 48'hA5A5_5A5A_F00F;
        alpha    = 6'd0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        got = out_data;
    endtask

    function automatic logic [47:0] bb_frame(input int k);
        logic signed [15:0] a, b, c;
        a = 16'(k * 111 + 1);
        b = 16'(-(k * 222) - 7);
        c = 16'(k * 1000 + 30000);
        return {c, b, a};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] got;
        logic [47:0] held;
        int          lat;
        int          acc, outs, low, ovc;
        int          acc_t[5];
        bit          acc_now;

        vecs[0]  = '{1'b1, 16'sd100,    -16'sd200,   16'sd32767, 6'd14, 16'sd100,    -16'sd200,   16'sd32767};
        vecs[1]  = '{1'b1, 16'sd0,      16'sd0,      16'sd0,     6'd14, 16'sd0,      16'sd0,      16'sd0};
        vecs[2]  = '{1'b0, 16'sd1000,   16'sd1000,   16'sd1000,  6'd14, 16'sd438,    16'sd438,    16'sd438};
        vecs[3]  = '{1'b0, 16'sd1000,   16'sd1000,   16'sd1000,  6'd14, 16'sd684,    16'sd684,    16'sd684};
        vecs[4]  = '{1'b1, 16'sd0,      16'sd0,      16'sd0,     6'd14, 16'sd0,      16'sd0,      16'sd0};
        vecs[5]  = '{1'b0, -16'sd1,     -16'sd3,     16'sd1000,  6'd14, 16'sd0,      -16'sd1,     16'sd438};
        vecs[6]  = '{1'b0, -16'sd3,     -16'sd3,     -16'sd3,    6'd14, -16'sd1,     -16'sd2,     16'sd245};
        vecs[7]  = '{1'b1, -16'sd32768, -16'sd32768, -16'sd32768, 6'd14, -16'sd32768, -16'sd32768, -16'sd32768};
        vecs[8]  = '{1'b0, 16'sd32767,  16'sd32767,  16'sd32767, 6'd14, -16'sd4096,  -16'sd4096,  -16'sd4096};
        vecs[9]  = '{1'b0, 16'sd5,      16'sd6,      16'sd7,     6'd0,  -16'sd4096,  -16'sd4096,  -16'sd4096};
        vecs[10] = '{1'b0, 16'sd123,    -16'sd456,   16'sd32767, 6'd40, 16'sd123,    -16'sd456,   16'sd32767};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        tick();

        // Table-driven frames
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_flush) pulse_flush();
            send(vecs[i].x0, vecs[i].x1, vecs[i].x2, vecs[i].al, got, lat);
            chk($sformatf("vec%0d_data", i), 64'(got), 64'({vecs[i].e2, vecs[i].e1, vecs[i].e0}));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        end

        // out_data holds between pulses
        held = {16'sd32767, -16'sd456, 16'sd123};
        repeat (5) tick();
        chk("hold_out_valid", 64'(out_valid), 64'd0);
        chk("hold_out_data", 64'(out_data), 64'(held));

        // Back-to-back: in_valid held for 5 frames, alpha=32 copies input
        alpha    = 6'd32;
        in_data  = bb_frame(0);
        in_valid = 1'b1;
        acc = 0; outs = 0; low = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (outs < 5) chk($sformatf("bb_out%0d", outs), 64'(out_data), 64'(bb_frame(outs)));
                outs++;
            end
            if (!in_ready) low++;
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) begin
                if (acc < 5) acc_t[acc] = c;
                acc++;
                if (acc >= 5) in_valid = 1'b0;
                else in_data = bb_frame(acc);
            end
        end
        chk("bb_accepts", 64'(acc), 64'd5);
        chk("bb_out_pulses", 64'(outs), 64'd5);
        chk("bb_ready_low", 64'(low), 64'd15);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("bb_spacing%0d", k), 64'(acc_t[k] - acc_t[k-1]), 64'd4);
        end

        // Flush during PROC: frame still filtered, next frame copied, then filtering resumes
        pulse_flush();
        send(16'sd0, 16'sd0, 16'sd0, 6'd14, got, lat);
        in_data  = {16'sd1000, 16'sd1000, 16'sd1000};
        alpha    = 6'd14;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        pulse_flush();
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("flush_proc_filtered", 64'(out_data), 64'({16'sd438, 16'sd438, 16'sd438}));
        send(16'sd7, -16'sd8, 16'sd9, 6'd14, got, lat);
        chk("flush_next_copied", 64'(got), 64'({16'sd9, -16'sd8, 16'sd7}));
        send(16'sd39, -16'sd8, 16'sd9, 6'd14, got, lat);
        chk("flush_reprimed", 64'(got), 64'({16'sd9, -16'sd8, 16'sd21}));

        // Reset during PROC: frame abandoned, outputs cleared, next frame primes
        in_data  = {16'sd1000, 16'sd1000, 16'sd1000};
        alpha    = 6'd14;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ovc = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) ovc++;
            tick();
        end
        chk("rstproc_no_valid", 64'(ovc), 64'd0);
        chk("rstproc_out_zero", 64'(out_data), 64'd0);
        send(16'sd555, -16'sd666, 16'sd777, 6'd14, got, lat);
        chk("rstproc_primes", 64'(got), 64'({16'sd777, -16'sd666, 16'sd555}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpf_multi.md
# lpf_multi

Multi-channel, runtime-configurable first-order IIR low-pass filter: y[n] = y[n-1] + alpha·(x[n] − y[n-1]), with alpha a fixed-point fraction. It sits between the IMU sample registers and the rate/attitude controllers and filters all axes of a sample frame (e.g. gyro X/Y/Z) with one shared multiplier, time-multiplexed over the channels. It adds three things over the single-channel filter:

- a ready/valid handshake;
- round-to-nearest with saturation;
- priming: the first sample after reset or flush loads straight into the filter state, so there is no startup ramp from zero.

## Interface
Parameters:
- WIDTH, 16, sample and state width in bits (signed two's complement).
- CHANNELS, 3, channels per frame (≥1).
- FRAC, 5, fractional bits of alpha; alpha = 2^FRAC represents 1.0.

Ports:
- clk  in  1  the single clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a frame is present on in_data.
- in_ready  out  1  the block can accept a frame.
- in_data  in  CHANNELS·WIDTH  packed signed samples; channel i occupies bits [i·WIDTH +: WIDTH].
- alpha  in  FRAC+1  unsigned filter coefficient, sampled at frame accept.
- flush  in  1  single-cycle request to re-prime the filter on the next frame.
- out_valid  out  1  one-cycle pulse: out_data holds a new filtered frame.
- out_data  out  CHANNELS·WIDTH  packed filtered outputs (registered).

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - PROC: in_ready=0. Channel counter ch runs 0..CHANNELS−1.
  - DONE: out_valid=1, in_ready=1.
- Accept happens when in_valid && in_ready. On accept:
  - latch in_data into the sample register;
  - latch alpha_eff = min(alpha, 2^FRAC);
  - go to PROC with ch=0.
- PROC updates one channel per cycle, ch incrementing. After ch=CHANNELS−1 the FSM goes to DONE, and out_data is loaded from the state registers in that transition.
- From DONE:
  - an accept in DONE goes to PROC, so frames run back-to-back;
  - otherwise the FSM returns to IDLE.
- Per-channel update, unprimed: y = x, with no arithmetic.
- Per-channel update, primed:
  - diff = x − y, computed WIDTH+1 bits signed;
  - prod = alpha_eff·diff, computed WIDTH+FRAC+2 bits signed;
  - r = (prod + 2^(FRAC−1)) >>> FRAC, an arithmetic shift, so halves round toward +∞;
  - y = sat_WIDTH(y + r), clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- primed flag:
  - cleared by rst or flush;
  - set in the cycle the FSM enters DONE;
  - sampled once at frame accept, so every channel of a frame is treated the same way.
- flush:
  - applies in any state;
  - an in-flight frame completes with the mode latched at its accept;
  - the next accepted frame primes;
  - the state registers themselves are untouched until that frame.
- A flush in the same cycle as entry to DONE wins: primed=0.
- alpha=0 holds the state unchanged; alpha ≥ 2^FRAC gives y = x.

## Timing
- Reset values:
  - state=IDLE, in_ready=0 while rst is asserted, out_valid=0, out_data=0;
  - all channel states=0, primed=0, ch=0.
- in_ready=1 in the first cycle after rst deasserts.
- Latency: an accept at edge T gives out_valid high during cycle T+CHANNELS+1.
- Throughput: one frame per CHANNELS+1 cycles when in_valid is held high.
- in_data and alpha may change freely after the accept edge.
- out_data holds its value between out_valid pulses.
- Channel states are never visible on out_data mid-frame.
- rst during PROC:
  - the frame is abandoned and no out_valid is produced;
  - all state registers are cleared;
  - the next frame primes.

## Structure
- Package lpf_pkg holds:
  - the FSM state enum (IDLE, PROC, DONE);
  - an alpha clamp function;
  - a generic signed saturate function.
- Sub-module lpf_update_core is a purely combinational single-channel update (x, y, alpha_eff, primed → y_next), parameterised by WIDTH and FRAC.
  - It is instantiated once.
  - Its inputs are multiplexed by ch.
- The top level holds:
  - the FSM and ch counter;
  - the sample register and the channel-state register array;
  - the output register and the primed flag.

## Test plan
Defaults throughout: WIDTH=16, CHANNELS=3, FRAC=5, alpha=14.
- Priming: reset, then accept frame (100, −200, 32767) → out_valid at cycle 4 after accept, out_data=(100, −200, 32767).
- Step response: prime with (0,0,0), then accept (1000,1000,1000) twice → outputs 438, then 684, on every channel.
- Rounding and negatives:
  - prime with 0, then x=−1 → y=0;
  - then x=−3 → y=−1;
  - prime with −32768, then x=32767 → y=−4096.
- Alpha bounds:
  - alpha=0 → output unchanged;
  - alpha=40, clamped to 32 → output equals input exactly.
- Back-to-back handshake: in_valid held high for 5 frames → accepts every 4 cycles, in_ready low for exactly 3 cycles per frame, 5 out_valid pulses, no frame lost or duplicated.
- Flush and reset:
  - flush during PROC → that frame is filtered, the next frame is copied verbatim;
  - rst during PROC → no out_valid, out_data=0, and the next frame primes.
